// File: rtl/binary_div_pkg.sv
// Shared definitions for the sequential signed restoring divider:
// FSM state encoding, default operand widths and iteration counter sizing.
package binary_div_pkg;

  localparam int DW_DEF = 5;
  localparam int VW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  localparam int CNT_W = cnt_width(DW_DEF);

endpackage

// File: rtl/binary_div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit,
// trial-subtract |B| and keep the difference only when it is non-negative.
module binary_div_step
  import binary_div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   prem,
  input  logic          dbit,
  input  logic [VW-1:0] abs_b,
  output logic [VW:0]   prem_nxt,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  // The extra top bit of diff acts as the borrow / sign of the trial subtraction.
  always_comb begin
    shifted  = {prem, dbit};
    diff     = shifted - {2'b00, abs_b};
    q_bit    = ~diff[VW+1];
    prem_nxt = q_bit ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/binary_div_5_3_seq.sv
// Sequential signed restoring divider: DW-bit dividend / VW-bit divisor,
// start/busy/done handshake, clock-enable gating, dbz and ovf flags.
module binary_div_5_3_seq
  import binary_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a_reg;
  logic [VW-1:0] b_reg;
  logic          sign_a;
  logic          sign_b;
  logic [DW-1:0] work;
  logic [VW-1:0] abs_b;
  logic [VW:0]   prem;
  logic [VW:0]   prem_nxt;
  logic          q_bit;
  logic          last_iter;

  assign last_iter = (cnt == CW'(DW - 1));

  binary_div_step #(.VW(VW)) u_step (
    .prem     (prem),
    .dbit     (work[DW-1]),
    .abs_b    (abs_b),
    .prem_nxt (prem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (B == '0) ? FIX : CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // |A| is kept as a DW-bit unsigned magnitude, which already covers 2^(DW-1);
  // work shifts the dividend out of its MSB and the quotient bits into its LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      work   <= '0;
      abs_b  <= '0;
      prem   <= '0;
      Q      <= '0;
      R      <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= A;
            b_reg  <= B;
            sign_a <= A[DW-1];
            sign_b <= B[VW-1];
            work   <= A[DW-1] ? -A : A;
            abs_b  <= B[VW-1] ? -B : B;
            prem   <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          work <= {work[DW-2:0], q_bit};
          prem <= prem_nxt;
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          if (b_reg == '0) begin
            Q   <= '0;
            R   <= '0;
            dbz <= 1'b1;
            ovf <= 1'b0;
          end else begin
            Q   <= (sign_a ^ sign_b) ? -work : work;
            R   <= sign_a ? -prem[VW-1:0] : prem[VW-1:0];
            dbz <= 1'b0;
            ovf <= (a_reg == {1'b1, {(DW-1){1'b0}}}) && (b_reg == '1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_div_5_3_seq.sv
// Scoreboard bench for binary_div_5_3_seq: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_binary_div_5_3_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [4:0] A;
  logic [2:0] B;
  logic [4:0] Q;
  logic [2:0] R;
  logic       busy;
  logic       done;
  logic       dbz;
  logic       ovf;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int ovf;
    int lat;
    int issue;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int timeouts = 0;
  bit end_req  = 0;
  bit end_ack  = 0;
  bit rst_checked = 0;
  int held_q = 0, held_r = 0, held_dbz = 0, held_ovf = 0;

  binary_div_5_3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: reset values, output holding while busy, and scoreboard pops on done.
  always @(negedge clk) begin
    exp_t  e;
    string tag;
    if (!rst_n) begin
      held_q = 0; held_r = 0; held_dbz = 0; held_ovf = 0;
      if (!rst_checked) begin
        checkOutput("reset_Q",    int'($signed(Q)), 0);
        checkOutput("reset_R",    int'($signed(R)), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_dbz",  int'(dbz), 0);
        checkOutput("reset_ovf",  int'(ovf), 0);
        rst_checked = 1;
      end
    end else begin
      rst_checked = 0;
      if (busy) begin
        checkOutput("hold_Q",   int'($signed(Q)), held_q);
        checkOutput("hold_R",   int'($signed(R)), held_r);
        checkOutput("hold_dbz", int'(dbz), held_dbz);
        checkOutput("hold_ovf", int'(ovf), held_ovf);
      end
      if (done && en) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          tag = $sformatf("(%0d/%0d)", e.a, e.b);
          checkOutput({"Q", tag},       int'($signed(Q)), e.q);
          checkOutput({"R", tag},       int'($signed(R)), e.r);
          checkOutput({"dbz", tag},     int'(dbz), e.dbz);
          checkOutput({"ovf", tag},     int'(ovf), e.ovf);
          checkOutput({"latency", tag}, cyc - e.issue, e.lat);
          held_q = e.q; held_r = e.r; held_dbz = e.dbz; held_ovf = e.ovf;
        end
      end
      if (end_req && !end_ack) begin
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        checkOutput("done_timeouts", timeouts, 0);
        end_ack = 1;
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; returns #1 after an edge, DUT idle.
  task automatic applyStimulus(input int a, input int b, input int eq, input int er,
                               input int edbz, input int eovf, input int elat,
                               input int pause_at, input int pause_len, input int poke_at);
    int  i;
    bit  seen;
    A = a[4:0];
    B = b[2:0];
    en = 1'b1;
    start = 1'b1;
    sb_q.push_back('{a: a, b: b, q: eq, r: er, dbz: edbz, ovf: eovf, lat: elat, issue: cyc});
    i = 0;
    seen = 0;
    while (!seen && i < 60) begin
      @(posedge clk);
      #1;
      i++;
      start = (i == poke_at);
      en = !(i >= pause_at && i < pause_at + pause_len);
      if (done) seen = 1;
    end
    start = 1'b0;
    en = 1'b1;
    if (!seen) begin
      timeouts++;
      $display("[TB] no done for %0d/%0d", a, b);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int a; int b; int q; int r; int dbz; int ovf; int lat;
  } vec_t;

  vec_t vecs[6] = '{
    '{ 13,  3,   4,  1, 0, 0, 7},
    '{-13,  3,  -4, -1, 0, 0, 7},
    '{ 13, -4,  -3,  1, 0, 0, 7},
    '{-15, -4,   3, -3, 0, 0, 7},
    '{-16, -1, -16,  0, 0, 1, 7},
    '{  7,  0,   0,  0, 1, 0, 2}
  };

  initial begin
    int eq, er, edbz, eovf, elat;
    rst_n = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    foreach (vecs[i])
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    vecs[i].dbz, vecs[i].ovf, vecs[i].lat, -1, 0, -1);

    $display("[TB] enable pause and ignored start while busy");
    applyStimulus(13, 3, 4, 1, 0, 0, 10, 2, 3, 1);

    $display("[TB] start with en low is ignored");
    en = 1'b0;
    start = 1'b1;
    A = 5'd13;
    B = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] reset during calculation");
    A = 5'd11;
    B = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(9, 2, 4, 1, 0, 0, 7, -1, 0, -1);

    $display("[TB] full sweep");
    for (int a = -16; a <= 15; a++) begin
      for (int b = -4; b <= 3; b++) begin
        if (b == 0) begin
          eq = 0; er = 0; edbz = 1; eovf = 0; elat = 2;
        end else if (a == -16 && b == -1) begin
          eq = -16; er = 0; edbz = 0; eovf = 1; elat = 7;
        end else begin
          eq = a / b; er = a % b; edbz = 0; eovf = 0; elat = 7;
        end
        applyStimulus(a, b, eq, er, edbz, eovf, elat, -1, 0, -1);
      end
    end

    end_req = 1;
    for (int w = 0; w < 5 && !end_ack; w++) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
